// File: rtl/fallthrough_fifo_small_if.sv
`default_nettype none
// ============================================================================
// Module   : fallthrough_fifo_small_if
// Brief    : Write/read handshake, head word and status flags of the small FWFT FIFO.
// Revision : 1.0 - initial release
// ============================================================================
interface fallthrough_fifo_small_if #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 3
);
  logic [WIDTH-1:0]        din;
  logic                    wr_en;
  logic                    rd_en;
  logic [WIDTH-1:0]        dout;
  logic                    full;
  logic                    nearly_full;
  logic                    prog_full;
  logic                    empty;
  logic [MAX_DEPTH_BITS:0] data_count;
  logic                    overflow;
  logic                    underflow;

  // Master is the producer/consumer side; slave is the FIFO itself.
  modport master (
    output din, wr_en, rd_en,
    input  dout, full, nearly_full, prog_full, empty, data_count, overflow, underflow
  );

  modport slave (
    input  din, wr_en, rd_en,
    output dout, full, nearly_full, prog_full, empty, data_count, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/fallthrough_fifo_small.sv
`default_nettype none
// ============================================================================
// Module   : fallthrough_fifo_small
// Brief    : Small synchronous first-word-fall-through FIFO; head word always on dout.
// Revision : 1.0 - initial release
// ============================================================================
module fallthrough_fifo_small #(
  parameter int WIDTH               = 72,
  parameter int MAX_DEPTH_BITS      = 3,
  parameter int PROG_FULL_THRESHOLD = 2**MAX_DEPTH_BITS - 1
) (
  input  wire logic               clk,
  input  wire logic               reset,
  fallthrough_fifo_small_if.slave fifo
);

  localparam int                      c_DEPTH     = 2**MAX_DEPTH_BITS;
  localparam logic [MAX_DEPTH_BITS:0] c_CNT_FULL  = (MAX_DEPTH_BITS+1)'(c_DEPTH);
  localparam logic [MAX_DEPTH_BITS:0] c_CNT_NFULL = (MAX_DEPTH_BITS+1)'(c_DEPTH - 1);
  localparam logic [MAX_DEPTH_BITS:0] c_CNT_PROG  = (MAX_DEPTH_BITS+1)'(PROG_FULL_THRESHOLD);

  logic [WIDTH-1:0]          r_mem [c_DEPTH];
  logic [MAX_DEPTH_BITS-1:0] r_wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] r_rd_ptr;
  logic [MAX_DEPTH_BITS:0]   r_count;
  logic                      r_overflow;
  logic                      r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;

  assign w_full  = (r_count == c_CNT_FULL);
  assign w_empty = (r_count == '0);

  // A write into a full FIFO still fits when the head is popped on the same edge.
  assign w_wr_acc = fifo.wr_en && (!w_full || fifo.rd_en);
  assign w_rd_acc = fifo.rd_en && !w_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_overflow  <= fifo.wr_en && !w_wr_acc;
      r_underflow <= fifo.rd_en && w_empty;
    end
  end

  // Storage is never cleared; a reset only suppresses the write on that edge.
  always_ff @(posedge clk) begin
    if (!reset && w_wr_acc) begin
      r_mem[r_wr_ptr] <= fifo.din;
    end
  end

  assign fifo.dout        = r_mem[r_rd_ptr];
  assign fifo.full        = w_full;
  assign fifo.empty       = w_empty;
  assign fifo.nearly_full = (r_count >= c_CNT_NFULL);
  assign fifo.prog_full   = (r_count >= c_CNT_PROG);
  assign fifo.data_count  = r_count;
  assign fifo.overflow    = r_overflow;
  assign fifo.underflow   = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fallthrough_fifo_small.sv
`default_nettype none
// ============================================================================
// Module   : tb_fallthrough_fifo_small
// Brief    : Vector table plus scoreboard queue for the small FWFT FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fallthrough_fifo_small;
  localparam int WIDTH = 72;
  localparam int MDB   = 3;
  localparam int DEPTH = 8;

  typedef struct {
    bit               wr;
    bit               rd;
    logic [WIDTH-1:0] din;
    int               cnt;
    bit               emp, ful, nf, pf, ovf, unf;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fallthrough_fifo_small_if #(.WIDTH(WIDTH), .MAX_DEPTH_BITS(MDB)) bus ();

  fallthrough_fifo_small #(
    .WIDTH(WIDTH), .MAX_DEPTH_BITS(MDB), .PROG_FULL_THRESHOLD(DEPTH-1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .fifo(bus)
  );

  int               n_cmp = 0;
  int               n_bad = 0;
  logic [WIDTH-1:0] sb[$];
  vec_t             tbl[$];

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(bit wr, bit rd, logic [WIDTH-1:0] d, int cnt,
                              bit emp, bit ful, bit nf, bit pf, bit ovf, bit unf);
    vec_t v;
    v.wr = wr; v.rd = rd; v.din = d; v.cnt = cnt;
    v.emp = emp; v.ful = ful; v.nf = nf; v.pf = pf; v.ovf = ovf; v.unf = unf;
    tbl.push_back(v);
  endfunction

  // Called at a negedge: checks the head, drives one cycle, checks state after the edge.
  task automatic step(input bit wr, input logic [WIDTH-1:0] d, input bit rd);
    int n;
    bit acc_w, acc_r, e_ovf, e_unf;
    n = sb.size();
    if (n > 0) chk("dout_head", bus.dout, sb[0]);
    bus.wr_en = wr;
    bus.rd_en = rd;
    bus.din   = d;
    acc_r = rd && (n > 0);
    acc_w = wr && ((n < DEPTH) || rd);
    e_ovf = wr && !acc_w;
    e_unf = rd && (n == 0);
    if (acc_r) void'(sb.pop_front());
    if (acc_w) sb.push_back(d);
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    n = sb.size();
    chk("data_count",  bus.data_count,  n);
    chk("empty",       bus.empty,       n == 0);
    chk("full",        bus.full,        n == DEPTH);
    chk("nearly_full", bus.nearly_full, n >= DEPTH-1);
    chk("prog_full",   bus.prog_full,   n >= DEPTH-1);
    chk("overflow",    bus.overflow,    e_ovf);
    chk("underflow",   bus.underflow,   e_unf);
  endtask

  initial begin
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.din   = '0;

    add(0, 0, 72'h0,  0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 72'hA1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 72'h0,  0, 1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 6; k++) add(1, 0, WIDTH'(k), k, 0, 0, 0, 0, 0, 0);
    add(1, 0, 72'h7, 7, 0, 0, 1, 1, 0, 0);
    add(1, 0, 72'h8, 8, 0, 1, 1, 1, 0, 0);
    add(1, 0, 72'h9, 8, 0, 1, 1, 1, 1, 0);
    add(0, 0, 72'h0, 8, 0, 1, 1, 1, 0, 0);
    add(0, 1, 72'h0, 7, 0, 0, 1, 1, 0, 0);
    for (int k = 6; k >= 0; k--) add(0, 1, 72'h0, k, k == 0, 0, 0, 0, 0, 0);
    add(0, 1, 72'h0, 0, 1, 0, 0, 0, 0, 1);
    add(0, 0, 72'h0, 0, 1, 0, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].wr, tbl[i].din, tbl[i].rd);
      chk($sformatf("v%0d_count", i), bus.data_count,  tbl[i].cnt);
      chk($sformatf("v%0d_empty", i), bus.empty,       tbl[i].emp);
      chk($sformatf("v%0d_full",  i), bus.full,        tbl[i].ful);
      chk($sformatf("v%0d_nfull", i), bus.nearly_full, tbl[i].nf);
      chk($sformatf("v%0d_pfull", i), bus.prog_full,   tbl[i].pf);
      chk($sformatf("v%0d_ovf",   i), bus.overflow,    tbl[i].ovf);
      chk($sformatf("v%0d_unf",   i), bus.underflow,   tbl[i].unf);
    end

    // Simultaneous read+write while full: head advances, new word lands last.
    for (int k = 1; k <= 8; k++) step(1'b1, WIDTH'(k), 1'b0);
    step(1'b1, 72'h99, 1'b1);
    chk("ff_head_is_2", bus.dout, 72'h2);
    chk("ff_still_full", bus.full, 1'b1);
    for (int k = 0; k < 7; k++) step(1'b0, '0, 1'b1);
    chk("ff_last_is_99", bus.dout, 72'h99);
    step(1'b0, '0, 1'b1);

    // Streaming through two pointer wraps at constant occupancy.
    step(1'b1, 72'h100, 1'b0);
    for (int k = 1; k <= 20; k++) step(1'b1, 72'h100 + WIDTH'(k), 1'b1);
    chk("stream_head", bus.dout, 72'h114);
    step(1'b0, '0, 1'b1);

    // Read from empty, and write-with-read from empty.
    step(1'b0, '0, 1'b1);
    step(1'b1, 72'h55, 1'b1);
    chk("empty_wr_rd_dout", bus.dout, 72'h55);
    step(1'b0, '0, 1'b1);

    // Reset at occupancy 5 overrides a concurrent write.
    for (int k = 0; k < 5; k++) step(1'b1, 72'h200 + WIDTH'(k), 1'b0);
    chk("pre_reset_count", bus.data_count, 4'd5);
    reset     = 1'b1;
    bus.wr_en = 1'b1;
    bus.din   = 72'hDEAD;
    @(negedge clk);
    reset     = 1'b0;
    bus.wr_en = 1'b0;
    sb.delete();
    chk("rst_count", bus.data_count, 4'd0);
    chk("rst_empty", bus.empty,      1'b1);
    chk("rst_full",  bus.full,       1'b0);
    chk("rst_ovf",   bus.overflow,   1'b0);
    chk("rst_unf",   bus.underflow,  1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 72'h300 + WIDTH'(k), 1'b0);
    chk("post_rst_head", bus.dout, 72'h300);
    for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fallthrough_fifo_small.md
Name: fallthrough_fifo_small

Overview:
- Small synchronous first-word-fall-through (FWFT) FIFO used as the input buffer of 64-bit/8-bit-ctrl datapath modules.
- Upstream writes {ctrl,data} words; downstream sees the head word on dout whenever the FIFO is non-empty, and pops it with rd_en.
- nearly_full drives upstream in_rdy, giving one word of slack for an in-flight write.

Parameters:
- WIDTH, 72, word width in bits (ctrl+data).
- MAX_DEPTH_BITS, 3, log2 of depth; depth = 2**MAX_DEPTH_BITS (default 8).
- PROG_FULL_THRESHOLD, 2**MAX_DEPTH_BITS-1, occupancy at which prog_full asserts.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- din  in  WIDTH  write data.
- wr_en  in  1  write request.
- rd_en  in  1  pop head word.
- dout  out  WIDTH  head-of-FIFO word (fall-through).
- full  out  1  occupancy == depth.
- nearly_full  out  1  occupancy >= depth-1.
- prog_full  out  1  occupancy >= PROG_FULL_THRESHOLD.
- empty  out  1  occupancy == 0.
- data_count  out  MAX_DEPTH_BITS+1  current occupancy, 0..depth.
- overflow  out  1  registered one-cycle pulse: write attempted while full and not accepted.
- underflow  out  1  registered one-cycle pulse: read attempted while empty.

Behaviour:
- Storage: depth x WIDTH register array. Write pointer and read pointer are MAX_DEPTH_BITS wide and wrap modulo depth. Count is MAX_DEPTH_BITS+1 wide.
- Reset (synchronous, clk edge with reset=1):
  - pointers, count, overflow and underflow go to 0; empty=1; full, nearly_full and prog_full go to 0.
  - Array contents are not cleared.
  - Reset overrides any simultaneous wr_en/rd_en.
- Write acceptance: wr_en && (!full || rd_en). An accepted write stores din at mem[wr_ptr] and advances wr_ptr by 1.
- Read acceptance: rd_en && !empty. An accepted read advances rd_ptr by 1.
- Count update:
  - +1 on accepted write only.
  - -1 on accepted read only.
  - Unchanged when both are accepted or neither is.
- Fall-through:
  - dout = mem[rd_ptr] combinationally from registered state.
  - A word written at edge N appears on dout, with empty=0, immediately after edge N (one-cycle write-to-visible latency).
  - No extra read latency: the word on dout is valid during the cycle rd_en is asserted. After the pop edge, dout shows the next word.
  - dout value is don't-care while empty=1.
- Flags: all derived combinationally from the registered count; none updates in the same cycle as the request.
- Boundary cases:
  - Write when empty with rd_en=1: write accepted, read ignored, underflow pulses.
  - rd_en and wr_en together when full: both accepted, count stays at depth, full stays 1.
  - Write when full without read: dropped, no state change, overflow pulses the next cycle. Simulation-only $display warning is permitted.
  - Read when empty: no state change, underflow pulses.
  - Pointer wrap from depth-1 to 0 is seamless; data order is preserved across the wrap.
- No combinational path from wr_en/rd_en to the flags. dout depends only on registered state.

Test Plan:
- Reset then idle -> empty=1, full=0, nearly_full=0, prog_full=0, data_count=0; overflow=underflow=0.
- Write 0xA1 once -> the cycle after the write edge: empty=0, dout=0xA1, data_count=1. Then pulse rd_en -> empty=1, data_count=0.
- Write 7 words 1..7 -> nearly_full=1 and prog_full=1 at count 7, full=0. Write 8th word -> full=1. Write 9th with rd_en=0 -> dropped, overflow pulses. Drain all -> dout sequence 1..8 in order.
- Fill to 8, then rd_en=1 and wr_en=1 with din=0x99 for one cycle -> count stays 8, full=1, head advances to 2, and 0x99 emerges last.
- Continuous streaming of 20 words with rd_en and wr_en both held (after one prefill) -> pointers wrap twice, output order is exact, count is constant.
- From empty, rd_en=1 -> underflow pulses one cycle, count stays 0. Assert reset mid-fill at count 5 -> next cycle empty=1, count=0, and subsequent writes read back correctly.
